// File: rtl/mux_pkg.sv
// Shared constants, FSM state type and select decode helper for the 8-to-1 mux datapath.
package mux_pkg;

  localparam int unsigned NCH   = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Decode a select index into its one-hot channel mask
  function automatic logic [NCH-1:0] onehot8(input logic [SEL_W-1:0] sel);
    onehot8 = NCH'(1) << sel;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping 7->0.
module rr_pick
  import mux_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [2*NCH-1:0] req_dbl;
  logic [NCH-1:0]   req_rot;
  logic [SEL_W-1:0] off;

  // Rotate so that bit 0 of req_rot is channel ptr
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[NCH-1:0];
  end

  // Priority-encode the lowest set bit of the rotated vector
  always_comb begin
    off = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req_rot[i]) off = SEL_W'(i);
    end
  end

  // Un-rotate back to an absolute channel index
  always_comb begin
    idx   = ptr + off;
    found = |req;
  end

endmodule

// File: rtl/mux_rr_sel.sv
// Round-robin select generator for the 8-to-1 mux with valid/ready and per-grant burst limit.
module mux_rr_sel
  import mux_pkg::*;
#(
  parameter int unsigned BURST = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [NCH-1:0]   i_req,
  input  logic             i_ready,
  output logic [SEL_W-1:0] o_sel,
  output logic [NCH-1:0]   o_grant,
  output logic             o_valid,
  output logic [NCH-1:0]   o_ack
);

  localparam int unsigned CNT_W = (BURST > 1) ? $clog2(BURST) : 1;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NCH-1:0]     grant_q, grant_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               req_cur;
  logic               xfer;
  logic               release_c;
  logic [SEL_W-1:0]   pick_ptr;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_found;

  // While granted, the only re-arbitration is on release, which scans from sel+1
  assign pick_ptr = (state_q == GRANT) ? (sel_q + SEL_W'(1)) : ptr_q;

  rr_pick u_pick (
    .req   (i_req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: initial grant from IDLE, burst counting, release and same-edge re-arbitration
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    release_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          grant_d = onehot8(pick_idx);
          cnt_d   = '0;
        end
      end
      GRANT: begin
        release_c = (xfer && (cnt_q == CNT_W'(BURST - 1))) || !req_cur;
        if (xfer) cnt_d = cnt_q + CNT_W'(1);
        if (release_c) begin
          ptr_d = pick_ptr;
          if (pick_found) begin
            sel_d   = pick_idx;
            grant_d = onehot8(pick_idx);
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Outputs: valid follows the granted channel's request; ack pulses on the transfer cycle
  always_comb begin
    req_cur = i_req[sel_q];
    o_valid = (state_q == GRANT) && req_cur;
    xfer    = o_valid && i_ready;
    o_ack   = xfer ? grant_q : '0;
    o_sel   = sel_q;
    o_grant = grant_q;
  end

endmodule

// File: tb/tb_mux_rr_sel.sv
// Bench for mux_rr_sel: BURST=4 and BURST=1 instances on shared stimulus, checked against a behavioural model.
module tb_mux_rr_sel;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       ready;

  logic [2:0] sel_o   [2];
  logic [7:0] grant_o [2];
  logic       valid_o [2];
  logic [7:0] ack_o   [2];

  int vectors     = 0;
  int miscompares = 0;

  // Model state per instance: granted channel (-1 = idle), priority pointer, transfers in grant, last select
  int m_g   [2];
  int m_ptr [2];
  int m_cnt [2];
  int m_last[2];
  int mb    [2] = '{4, 1};

  int e_sel, e_grant, e_valid, e_ack;
  bit rst_pend;

  mux_rr_sel #(.BURST(4)) u_dut4 (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_req     (req),
    .i_ready   (ready),
    .o_sel     (sel_o[0]),
    .o_grant   (grant_o[0]),
    .o_valid   (valid_o[0]),
    .o_ack     (ack_o[0])
  );

  mux_rr_sel #(.BURST(1)) u_dut1 (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_req     (req),
    .i_ready   (ready),
    .o_sel     (sel_o[1]),
    .o_grant   (grant_o[1]),
    .o_valid   (valid_o[1]),
    .o_ack     (ack_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (burst=%0d) got=%0h want=%0h at %0t", nm, mb[d], act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      int c;
      c = (p + k) % 8;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset(input int d);
    m_g[d]    = -1;
    m_ptr[d]  = 0;
    m_cnt[d]  = 0;
    m_last[d] = 0;
  endtask

  task automatic model_grant(input int d, input int p);
    if (p >= 0) begin
      m_g[d]    = p;
      m_cnt[d]  = 0;
      m_last[d] = p;
    end else begin
      m_g[d] = -1;
    end
  endtask

  // Advance the model by one clock edge using the inputs held across it
  task automatic model_step(input int d);
    int  g;
    bit  xf;
    bit  at_limit;
    g = m_g[d];
    if (g < 0) begin
      model_grant(d, pick(req, m_ptr[d]));
    end else begin
      xf       = req[g] && ready;
      at_limit = (m_cnt[d] == mb[d] - 1);
      if (xf) m_cnt[d]++;
      if ((xf && at_limit) || !req[g]) begin
        m_ptr[d] = (g + 1) % 8;
        model_grant(d, pick(req, m_ptr[d]));
      end
    end
  endtask

  // Compare both instances against the model every cycle, mid-period
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) model_reset(d);
      if (m_g[d] >= 0) begin
        e_sel   = m_g[d];
        e_grant = 1 << m_g[d];
        e_valid = req[m_g[d]] ? 1 : 0;
        e_ack   = (e_valid != 0 && ready) ? e_grant : 0;
      end else begin
        e_sel   = m_last[d];
        e_grant = 0;
        e_valid = 0;
        e_ack   = 0;
      end
      chk("model_sel",   d, 32'(sel_o[d]),   32'(e_sel));
      chk("model_grant", d, 32'(grant_o[d]), 32'(e_grant));
      chk("model_valid", d, 32'(valid_o[d]), 32'(e_valid));
      chk("model_ack",   d, 32'(ack_o[d]),   32'(e_ack));
      if (rst_n) model_step(d);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] exp_ack;
    int         exp_sel;

    rst_n    = 1'b0;
    req      = 8'hFF;
    ready    = 1'b1;
    rst_pend = 1'b0;

    // Reset with all requests high: everything zero
    cyc(); cyc();
    at_neg();
    chk("rst_sel",   0, 32'(sel_o[0]),   32'h0);
    chk("rst_grant", 0, 32'(grant_o[0]), 32'h0);
    chk("rst_valid", 0, 32'(valid_o[0]), 32'h0);
    chk("rst_ack",   0, 32'(ack_o[0]),   32'h0);
    chk("rst_grant", 1, 32'(grant_o[1]), 32'h0);

    // Release; first grant appears one cycle after the sampling edge
    cyc();
    rst_n = 1'b1;
    at_neg();
    chk("pre_grant", 0, 32'(grant_o[0]), 32'h0);
    cyc();
    at_neg();
    chk("first_sel",   0, 32'(sel_o[0]),   32'h0);
    chk("first_grant", 0, 32'(grant_o[0]), 32'h01);
    chk("first_valid", 0, 32'(valid_o[0]), 32'h1);
    chk("first_grant", 1, 32'(grant_o[1]), 32'h01);

    // Full rotation with BURST=1: sel 0..7,0 and walking ack
    for (int i = 0; i < 9; i++) begin
      if (i != 0) begin
        cyc();
        at_neg();
      end
      exp_ack = 8'(1 << (i % 8));
      chk("rot_sel", 1, 32'(sel_o[1]), 32'(i % 8));
      chk("rot_ack", 1, 32'(ack_o[1]), 32'(exp_ack));
    end

    // Async reset between edges while BURST=4 instance is mid-burst on channel 2
    cyc();
    chk("pre_rst_sel", 0, 32'(sel_o[0]), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_sel",   0, 32'(sel_o[0]),   32'h0);
    chk("async_grant", 0, 32'(grant_o[0]), 32'h0);
    chk("async_valid", 0, 32'(valid_o[0]), 32'h0);
    chk("async_ack",   0, 32'(ack_o[0]),   32'h0);
    chk("async_grant", 1, 32'(grant_o[1]), 32'h0);

    // Burst limit: channel 3 for exactly 4 acks, then channel 4 without a gap
    req = 8'h18;
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      at_neg();
      if (k < 4) begin
        chk("burst_sel", 0, 32'(sel_o[0]), 32'h3);
        chk("burst_ack", 0, 32'(ack_o[0]), 32'h08);
      end else begin
        chk("handoff_sel", 0, 32'(sel_o[0]), 32'h4);
        chk("handoff_ack", 0, 32'(ack_o[0]), 32'h10);
      end
    end

    // Abort channel 4 (ptr becomes 5), then wrap: 7, 2, 7
    cyc();
    req = 8'h84;
    at_neg();
    chk("abort_sel",   0, 32'(sel_o[0]),   32'h4);
    chk("abort_valid", 0, 32'(valid_o[0]), 32'h0);
    chk("abort_ack",   0, 32'(ack_o[0]),   32'h0);
    for (int k = 0; k < 9; k++) begin
      cyc();
      at_neg();
      exp_sel = (k < 4) ? 7 : ((k < 8) ? 2 : 7);
      chk("wrap_sel", 0, 32'(sel_o[0]), 32'(exp_sel));
    end
    chk("wrap_ack", 0, 32'(ack_o[0]), 32'h80);

    // Backpressure on channel 2 for 5 cycles, then one accepted word
    cyc();
    rst_n = 1'b0;
    req   = 8'h04;
    ready = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    for (int k = 0; k < 5; k++) begin
      at_neg();
      chk("bp_sel",   0, 32'(sel_o[0]),   32'h2);
      chk("bp_valid", 0, 32'(valid_o[0]), 32'h1);
      chk("bp_ack",   0, 32'(ack_o[0]),   32'h0);
      cyc();
    end
    ready = 1'b1;
    at_neg();
    chk("bp_release_ack", 0, 32'(ack_o[0]), 32'h04);

    // Abort while stalled: channel 2 drops, channel 5 granted next cycle
    cyc();
    ready = 1'b0;
    req   = 8'h20;
    at_neg();
    chk("stall_abort_valid", 0, 32'(valid_o[0]), 32'h0);
    chk("stall_abort_ack",   0, 32'(ack_o[0]),   32'h0);
    cyc();
    at_neg();
    chk("stall_abort_sel",   0, 32'(sel_o[0]),   32'h5);
    chk("stall_abort_grant", 0, 32'(grant_o[0]), 32'h20);

    // Randomised traffic: slowly changing requests, random ready, occasional mid-cycle reset
    req = 8'($urandom);
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (rst_pend) begin
        rst_n    = 1'b1;
        rst_pend = 1'b0;
      end
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      end
      if ($urandom_range(0, 59) == 0) req = 8'h00;
      ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 199) == 0) begin
        #1;
        rst_n    = 1'b0;
        rst_pend = 1'b1;
      end
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    at_neg();
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
